data_memory_responder: RTL and testbench

//  Memory-side responder for the pipeline processor's data port. Every cycle it

---
 rtl/data_memory_responder.sv | 146 ++++++++++++++
 tb/tb_data_memory_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_responder
//  Purpose  : Memory-side responder for a pipelined core's data port.
//             Writes commit at the accept edge; reads return after a fixed
//             READ_LATENCY register pipeline. After reset a sweep FSM
//             zero-fills the whole array before any access is served.
//  Options  : MEM_ACCESS_COUNT_EN -- when defined, adds saturating
//             ReadCount/WriteCount access counters.
//  Ports    : Clock      in  system clock (posedge)
//             Reset      in  asynchronous active-low reset
//             Daddress   in  word address; low ADDR_BITS index the array
//             Dout       in  write data
//             W          in  1 = write, 0 = read
//             Req        in  access valid this cycle
//             DataIn     out read data (holds last value between responses)
//             DataValid  out DataIn carries a read response this cycle
//             Ready      out accepting accesses (0 during the clear sweep)
//             AddrError  out accepted access had nonzero upper address bits
//             ReadCount  out accepted reads, saturating  (MEM_ACCESS_COUNT_EN)
//             WriteCount out accepted writes, saturating (MEM_ACCESS_COUNT_EN)
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
  parameter int DATA_WIDTH   = 20,
  parameter int ADDR_BITS    = 8,
  parameter int READ_LATENCY = 2   // legal range 1..4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [19:0]           Daddress,
  input  logic [DATA_WIDTH-1:0] Dout,
  input  logic                  W,
  input  logic                  Req,
  output logic [DATA_WIDTH-1:0] DataIn,
  output logic                  DataValid,
  output logic                  Ready,
  output logic                  AddrError
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]           ReadCount,
  output logic [15:0]           WriteCount
`endif
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state, next_state;
  logic [ADDR_BITS-1:0]    ptr;
  logic [ADDR_BITS-1:0]    idx;
  logic                    accept, rd_accept, wr_accept;
  logic                    addr_oor;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [DATA_WIDTH-1:0]   pipe_dat [READ_LATENCY];

  // --------------------------------------------------------------------------
  // Sweep / ready FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= CLEAR;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    Ready      = 1'b0;
    case (state)
      // Leave CLEAR on the edge that writes the last word, so the sweep
      // occupies exactly DEPTH cycles.
      CLEAR: if (&ptr) next_state = READY;
      READY: Ready = 1'b1;
      default: next_state = CLEAR;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)              ptr <= '0;
    else if (state == CLEAR) ptr <= ptr + 1'b1;
  end

  // --------------------------------------------------------------------------
  // Access decode
  // --------------------------------------------------------------------------
  assign idx       = Daddress[ADDR_BITS-1:0];
  assign addr_oor  = (Daddress >> ADDR_BITS) != '0;
  assign accept    = Ready & Req;
  assign rd_accept = accept & ~W;
  assign wr_accept = accept &  W;

  // Array has no reset; the sweep is what initialises it.
  always_ff @(posedge Clock) begin
    if (state == CLEAR)  mem[ptr] <= '0;
    else if (wr_accept)  mem[idx] <= Dout;
  end

  // --------------------------------------------------------------------------
  // Read pipeline: stage 0 samples the array at the accept edge, so a write
  // one cycle earlier is already visible without forwarding. Data registers
  // only move with a valid token, which makes DataIn hold between responses.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_vld[k] <= 1'b0;
        pipe_dat[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_accept;
      if (rd_accept) pipe_dat[0] <= mem[idx];
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        if (pipe_vld[k-1]) pipe_dat[k] <= pipe_dat[k-1];
      end
    end
  end

  assign DataValid = pipe_vld[READ_LATENCY-1];
  assign DataIn    = pipe_dat[READ_LATENCY-1];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) AddrError <= 1'b0;
    else        AddrError <= accept & addr_oor;
  end

`ifdef MEM_ACCESS_COUNT_EN
  // accept already excludes the sweep, so CLEAR-time requests never count.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ReadCount  <= '0;
      WriteCount <= '0;
    end else begin
      if (rd_accept && ReadCount  != 16'hFFFF) ReadCount  <= ReadCount  + 16'd1;
      if (wr_accept && WriteCount != 16'hFFFF) WriteCount <= WriteCount + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory_responder
//  Purpose  : Scoreboard bench for data_memory_responder. A stimulus process
//             drives directed and random accesses and pushes expected read
//             responses / address-error cycles into queues; a monitor on the
//             falling edge pops and compares whatever the DUT presents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

  localparam int DW    = 20;
  localparam int AB    = 8;
  localparam int RL    = 2;
  localparam int DEPTH = 256;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic [19:0]   Daddress = '0;
  logic [DW-1:0] Dout = '0;
  logic          W = 1'b0;
  logic          Req = 1'b0;
  logic [DW-1:0] DataIn;
  logic          DataValid;
  logic          Ready;
  logic          AddrError;
`ifdef MEM_ACCESS_COUNT_EN
  logic [15:0]   ReadCount;
  logic [15:0]   WriteCount;
`endif

  data_memory_responder #(
    .DATA_WIDTH  (DW),
    .ADDR_BITS   (AB),
    .READ_LATENCY(RL)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Daddress  (Daddress),
    .Dout      (Dout),
    .W         (W),
    .Req       (Req),
    .DataIn    (DataIn),
    .DataValid (DataValid),
    .Ready     (Ready),
    .AddrError (AddrError)
`ifdef MEM_ACCESS_COUNT_EN
    ,
    .ReadCount (ReadCount),
    .WriteCount(WriteCount)
`endif
  );

  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    int            due;   // edge after which DataValid must be seen
  } exp_t;

  exp_t          rdq[$];
  int            aerrq[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            edge_n   = 0;
  int            rel_edge = 1 << 30;
  bit            in_reset = 1'b1;
  logic [DW-1:0] last_data = '0;
  int            n_rd = 0, n_wr = 0;
  int            total = 0, bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    edge_n++;
    #1;
  endtask

  // Drive one cycle of inputs; the model decides acceptance from its own
  // notion of when the sweep finishes, not from the DUT's Ready.
  task automatic issue(bit req, bit w, logic [19:0] a, logic [DW-1:0] d);
    exp_t          e;
    logic [AB-1:0] ix;
    logic [19:0]   upper;
    bit            acc;
    Req = req; W = w; Daddress = a; Dout = d;
    acc   = req && !in_reset && (edge_n >= rel_edge + DEPTH);
    ix    = a[AB-1:0];
    upper = a >> AB;
    if (acc) begin
      if (w) begin
        model_mem[ix] = d;
        n_wr++;
      end else begin
        e.data = model_mem[ix];
        e.due  = edge_n + RL;
        rdq.push_back(e);
        n_rd++;
      end
      if (upper != 0) aerrq.push_back(edge_n + 1);
    end
    tick();
  endtask

  task automatic rand_access(int n);
    logic [19:0] a;
    for (int i = 0; i < n; i++) begin
      a = 20'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a | (20'($urandom_range(1, 4095)) << AB);
      issue($urandom_range(0, 9) < 7, 1'($urandom), a, DW'($urandom));
    end
  endtask

  // Assert reset (random Req activity during it is dropped), then release
  // and let the sweep run with random requests that must also be dropped.
  task automatic do_reset(int hold);
    Req       = 1'b0;
    Reset     = 1'b0;
    in_reset  = 1'b1;
    rel_edge  = 1 << 30;
    rdq.delete();
    aerrq.delete();
    last_data = '0;
    n_rd = 0; n_wr = 0;
    for (int i = 0; i < hold; i++) issue(1'b1, 1'($urandom), 20'($urandom), DW'($urandom));
    Reset    = 1'b1;
    in_reset = 1'b0;
    rel_edge = edge_n;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    for (int i = 0; i < DEPTH; i++)
      issue($urandom_range(0, 3) == 0, 1'($urandom), 20'($urandom_range(0, 255)), DW'($urandom));
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clock) begin
    exp_t e;
    bit   aerr_exp;
    if (in_reset) begin
      check("rst_valid", 32'(DataValid), 0);
      check("rst_ready", 32'(Ready), 0);
      check("rst_aerr",  32'(AddrError), 0);
      check("rst_data",  32'(DataIn), 0);
    end else begin
      check("ready", 32'(Ready), 32'(edge_n >= rel_edge + DEPTH));
      aerr_exp = 1'b0;
      if (aerrq.size() > 0 && aerrq[0] <= edge_n) begin
        aerr_exp = (aerrq[0] == edge_n);
        void'(aerrq.pop_front());
      end
      check("addr_error", 32'(AddrError), 32'(aerr_exp));
      if (DataValid) begin
        if (rdq.size() == 0) begin
          total++; bad++;
          $display("FAIL stale_valid: got DataValid=1 data=%0h expected no response (edge %0d)", DataIn, edge_n);
        end else begin
          e = rdq.pop_front();
          check("rd_latency", 32'(edge_n), 32'(e.due));
          check("rd_data", 32'(DataIn), 32'(e.data));
          last_data = e.data;
        end
      end else begin
        check("hold_data", 32'(DataIn), 32'(last_data));
        if (rdq.size() > 0 && rdq[0].due <= edge_n) begin
          total++; bad++;
          $display("FAIL missing_valid: got DataValid=0 expected data %0h (edge %0d)", rdq[0].data, edge_n);
          void'(rdq.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset(3);
    issue(1'b0, 1'b0, 20'h0, '0);

    // Every word reads back zero after the sweep.
    for (int i = 0; i < 6; i++) issue(1'b1, 1'b0, 20'($urandom_range(0, 255)), '0);
    issue(1'b1, 1'b0, 20'h000FF, '0);

    // Write then immediately read the same word.
    issue(1'b1, 1'b1, 20'h00005, 20'hABCDE);
    issue(1'b1, 1'b0, 20'h00005, '0);
    issue(1'b0, 1'b0, 20'h0, '0);

    // Back-to-back reads of pre-written words.
    issue(1'b1, 1'b1, 20'h00001, 20'd11);
    issue(1'b1, 1'b1, 20'h00002, 20'd22);
    issue(1'b1, 1'b1, 20'h00003, 20'd33);
    issue(1'b1, 1'b0, 20'h00001, '0);
    issue(1'b1, 1'b0, 20'h00002, '0);
    issue(1'b1, 1'b0, 20'h00003, '0);
    issue(1'b0, 1'b0, 20'h0, '0);

    // Out-of-range upper bits wrap to word 5 and flag AddrError.
    issue(1'b1, 1'b0, 20'h00105, '0);
    issue(1'b1, 1'b1, 20'hFFF07, 20'h12345);
    issue(1'b1, 1'b0, 20'h00007, '0);
    repeat (3) issue(1'b0, 1'b0, 20'h0, '0);

    rand_access(300);

    // Reset with two reads in flight: nothing stale may appear afterwards.
    issue(1'b1, 1'b0, 20'h00005, '0);
    issue(1'b1, 1'b0, 20'h00001, '0);
    do_reset(2);
    repeat (RL + 2) issue(1'b0, 1'b0, 20'h0, '0);
    issue(1'b1, 1'b0, 20'h00005, '0);

    rand_access(150);
    repeat (RL + 3) issue(1'b0, 1'b0, 20'h0, '0);
    check("drain", 32'(rdq.size()), 0);

`ifdef MEM_ACCESS_COUNT_EN
    check("read_count",  32'(ReadCount),  32'(n_rd));
    check("write_count", 32'(WriteCount), 32'(n_wr));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
